// File: rtl/rib_xbar_pkg.sv
// Shared definitions for the RIB crossbar: FSM encoding and slave-select width.
package rib_xbar_pkg;

  localparam int RIB_SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } rib_state_e;

endpackage

// File: rtl/rib_xbar_rr_arbiter.sv
// Combinational winner select: fixed top-priority master, round-robin among
// the others starting after ptr. Produces a one-hot grant and its index.
module rib_rr_arbiter #(
  parameter int NUM_M  = 4,
  parameter int PRIO_M = 3,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NUM_M-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  logic found;
  int   cand;

  // NOTE: always_comb uses blocking assignments and gives every output a
  // default first, so no path through the block can infer a latch.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    if (req[PRIO_M]) begin
      gnt[PRIO_M] = 1'b1;
      idx         = IDX_W'(PRIO_M);
    end else begin
      for (int k = 1; k <= NUM_M; k++) begin
        cand = (int'(ptr) + k) % NUM_M;
        if (!found && cand != PRIO_M && req[cand]) begin
          found     = 1'b1;
          gnt[cand] = 1'b1;
          idx       = IDX_W'(cand);
        end
      end
    end
  end

endmodule

// File: rtl/rib_xbar.sv
// Registered shared-bus crossbar: NUM_M masters to NUM_S synchronous-read
// slaves, one transaction in flight, decode-error response for unmapped selects.
module rib_xbar
  import rib_xbar_pkg::*;
#(
  parameter int               NUM_M     = 4,
  parameter int               NUM_S     = 6,
  parameter int               AW        = 32,
  parameter int               DW        = 32,
  parameter int               SEL_W     = RIB_SEL_W,
  parameter int               PRIO_M    = 3,
  parameter logic [NUM_M-1:0] HOLD_MASK = NUM_M'(4'b1101)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_M-1:0]    m_req_i,
  input  logic [NUM_M-1:0]    m_we_i,
  input  logic [NUM_M*AW-1:0] m_addr_i,
  input  logic [NUM_M*DW-1:0] m_data_i,
  output logic [NUM_M-1:0]    m_gnt_o,
  output logic [NUM_M-1:0]    m_rvalid_o,
  output logic [NUM_M-1:0]    m_err_o,
  output logic [NUM_M*DW-1:0] m_data_o,
  output logic [NUM_S-1:0]    s_req_o,
  output logic [NUM_S-1:0]    s_we_o,
  output logic [NUM_S*AW-1:0] s_addr_o,
  output logic [NUM_S*DW-1:0] s_data_o,
  input  logic [NUM_S*DW-1:0] s_data_i,
  output logic                hold_flag_o
);

  localparam int IDX_W = $clog2(NUM_M);

  rib_state_e       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] win_idx;
  logic [NUM_M-1:0] arb_gnt;
  logic             arb_en;
  logic             any_req;

  logic [IDX_W-1:0] lat_idx;
  logic [AW-1:0]    lat_addr;
  logic [DW-1:0]    lat_data;
  logic             lat_we;
  logic [SEL_W-1:0] lat_sel;
  logic             err_flag;
  logic             sel_ok;

  logic [AW-1:0]    win_addr;
  logic [DW-1:0]    rd_data;

  rib_rr_arbiter #(
    .NUM_M  (NUM_M),
    .PRIO_M (PRIO_M),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req (m_req_i),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (win_idx)
  );

  assign any_req  = |m_req_i;
  // A grant shown while rst is high would be lost at the reset edge.
  assign arb_en   = (state == ST_IDLE || state == ST_RESP) && !rst;
  assign m_gnt_o  = arb_en ? arb_gnt : '0;
  assign win_addr = m_addr_i[win_idx*AW +: AW];
  assign sel_ok   = int'(lat_sel) < NUM_S;

  assign hold_flag_o = (|(m_req_i & HOLD_MASK)) || (state == ST_ACCESS);

  // NOTE: state and latched payload use non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= IDX_W'(NUM_M - 1);
      lat_idx  <= '0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_we   <= 1'b0;
      lat_sel  <= '0;
      err_flag <= 1'b0;
    end else begin
      if (arb_en && any_req) begin
        lat_idx  <= win_idx;
        lat_addr <= win_addr;
        lat_data <= m_data_i[win_idx*DW +: DW];
        lat_we   <= m_we_i[win_idx];
        lat_sel  <= win_addr[AW-1 -: SEL_W];
        if (int'(win_idx) != PRIO_M) rr_ptr <= win_idx;
      end
      unique case (state)
        ST_IDLE:   if (any_req) state <= ST_ACCESS;
        ST_ACCESS: begin
          state    <= ST_RESP;
          err_flag <= !sel_ok;
        end
        ST_RESP:   state <= any_req ? ST_ACCESS : ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  for (genvar s = 0; s < NUM_S; s++) begin : g_slave
    logic hit;
    assign hit                    = (state == ST_ACCESS) && sel_ok && (lat_sel == SEL_W'(s));
    assign s_req_o[s]             = hit;
    assign s_we_o[s]              = hit && lat_we;
    assign s_addr_o[s*AW +: AW]   = hit ? {{SEL_W{1'b0}}, lat_addr[AW-SEL_W-1:0]} : '0;
    assign s_data_o[s*DW +: DW]   = hit ? lat_data : '0;
  end

  always_comb begin
    rd_data = '0;
    for (int s = 0; s < NUM_S; s++) begin
      if (lat_sel == SEL_W'(s)) rd_data = s_data_i[s*DW +: DW];
    end
  end

  for (genvar m = 0; m < NUM_M; m++) begin : g_master
    logic resp;
    assign resp                 = (state == ST_RESP) && (lat_idx == IDX_W'(m));
    assign m_rvalid_o[m]        = resp;
    assign m_err_o[m]           = resp && err_flag;
    assign m_data_o[m*DW +: DW] = (resp && !lat_we && !err_flag) ? rd_data : '0;
  end

endmodule

// File: tb/tb_rib_xbar.sv
// Directed per-cycle vector bench for rib_xbar with the default 4x6 configuration,
// plus a hand-written reset-during-response sequence.
module tb_rib_xbar;

  localparam int NUM_M = 4;
  localparam int NUM_S = 6;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic [NUM_M-1:0]    m_req_i, m_we_i;
  logic [NUM_M*AW-1:0] m_addr_i;
  logic [NUM_M*DW-1:0] m_data_i;
  logic [NUM_M-1:0]    m_gnt_o, m_rvalid_o, m_err_o;
  logic [NUM_M*DW-1:0] m_data_o;
  logic [NUM_S-1:0]    s_req_o, s_we_o;
  logic [NUM_S*AW-1:0] s_addr_o;
  logic [NUM_S*DW-1:0] s_data_o, s_data_i;
  logic                hold_flag_o;

  rib_xbar dut (
    .clk         (clk),
    .rst         (rst),
    .m_req_i     (m_req_i),
    .m_we_i      (m_we_i),
    .m_addr_i    (m_addr_i),
    .m_data_i    (m_data_i),
    .m_gnt_o     (m_gnt_o),
    .m_rvalid_o  (m_rvalid_o),
    .m_err_o     (m_err_o),
    .m_data_o    (m_data_o),
    .s_req_o     (s_req_o),
    .s_we_o      (s_we_o),
    .s_addr_o    (s_addr_o),
    .s_data_o    (s_data_o),
    .s_data_i    (s_data_i),
    .hold_flag_o (hold_flag_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [3:0]  gnt;
    logic [3:0]  rv;
    logic [3:0]  err;
    logic [5:0]  sreq;
    logic [5:0]  swe;
    logic        hold;
    logic [31:0] rdata;
    logic [31:0] saddr;
    logic [31:0] sdata;
  } vec_t;

  localparam logic [31:0] SD0 = 32'h5000_0000;
  localparam logic [31:0] SD1 = 32'hDEAD_BEEF;
  localparam logic [31:0] SD2 = 32'h5000_0002;
  localparam logic [31:0] WD0 = 32'hC0DE_0000;
  localparam logic [31:0] WD1 = 32'hC0DE_0001;
  localparam logic [31:0] WD2 = 32'hC0DE_0002;
  localparam logic [31:0] WD3 = 32'hC0DE_0003;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   cur_row = 0;

  function automatic vec_t v(logic r, logic [3:0] req, logic [3:0] we, logic [31:0] addr,
                             logic [3:0] gnt, logic [3:0] rv, logic [3:0] err,
                             logic [5:0] sreq, logic [5:0] swe, logic hold,
                             logic [31:0] rdata, logic [31:0] saddr, logic [31:0] sdata);
    vec_t t;
    t.rst = r; t.req = req; t.we = we; t.addr = addr;
    t.gnt = gnt; t.rv = rv; t.err = err; t.sreq = sreq; t.swe = swe;
    t.hold = hold; t.rdata = rdata; t.saddr = saddr; t.sdata = sdata;
    return t;
  endfunction

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, cur_row, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] req, input logic [3:0] we,
                       input logic [31:0] addr);
    rst      = r;
    m_req_i  = req;
    m_we_i   = we;
    m_addr_i = {4{addr}};
  endtask

  task automatic check_vec(input vec_t t);
    logic [NUM_M*DW-1:0] exp_mdata;
    logic [NUM_S*AW-1:0] exp_saddr;
    logic [NUM_S*DW-1:0] exp_sdata;
    exp_mdata = '0;
    exp_saddr = '0;
    exp_sdata = '0;
    for (int i = 0; i < NUM_M; i++) if (t.rv[i]) exp_mdata[i*DW +: DW] = t.rdata;
    for (int s = 0; s < NUM_S; s++) begin
      if (t.sreq[s]) begin
        exp_saddr[s*AW +: AW] = t.saddr;
        exp_sdata[s*DW +: DW] = t.sdata;
      end
    end
    check("gnt",    192'(m_gnt_o),     192'(t.gnt));
    check("rvalid", 192'(m_rvalid_o),  192'(t.rv));
    check("err",    192'(m_err_o),     192'(t.err));
    check("s_req",  192'(s_req_o),     192'(t.sreq));
    check("s_we",   192'(s_we_o),      192'(t.swe));
    check("hold",   192'(hold_flag_o), 192'(t.hold));
    check("m_data", 192'(m_data_o),    192'(exp_mdata));
    check("s_addr", 192'(s_addr_o),    192'(exp_saddr));
    check("s_data", 192'(s_data_o),    192'(exp_sdata));
    check("onehot", 192'($onehot0(m_gnt_o) && $onehot0(m_rvalid_o) && $onehot0(s_req_o)), 192'(1));
  endtask

  initial begin
    // Reset, single read (m0 -> slave 1)
    vecs.push_back(v(1, 4'b0000, 4'b0000, 32'h0,         4'b0000, 4'b0000, 4'b0000, 6'b000000, 6'b000000, 0, 0,   0,      0));
    vecs.push_back(v(0, 4'b0001, 4'b0000, 32'h1000_0040, 4'b0001, 4'b0000, 4'b0000, 6'b000000, 6'b000000, 1, 0,   0,      0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 32'h1000_0040, 4'b0000, 4'b0000, 4'b0000, 6'b000010, 6'b000000, 1, 0,   32'h40, WD0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 32'h1000_0040, 4'b0000, 4'b0001, 4'b0000, 6'b000000, 6'b000000, 0, SD1, 0,      0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 32'h0,         4'b0000, 4'b0000, 4'b0000, 6'b000000, 6'b000000, 0, 0,   0,      0));
    // Priority m3, then m1/m2 round-robin
    vecs.push_back(v(0, 4'b1110, 4'b0000, 32'h10, 4'b1000, 4'b0000, 4'b0000, 6'b000000, 6'b000000, 1, 0,   0,     0));
    vecs.push_back(v(0, 4'b0110, 4'b0000, 32'h10, 4'b0000, 4'b0000, 4'b0000, 6'b000001, 6'b000000, 1, 0,   32'h10, WD3));
    vecs.push_back(v(0, 4'b0110, 4'b0000, 32'h10, 4'b0010, 4'b1000, 4'b0000, 6'b000000, 6'b000000, 1, SD0, 0,     0));
    vecs.push_back(v(0, 4'b0110, 4'b0000, 32'h10, 4'b0000, 4'b0000, 4'b0000, 6'b000001, 6'b000000, 1, 0,   32'h10, WD1));
    vecs.push_back(v(0, 4'b0110, 4'b0000, 32'h10, 4'b0100, 4'b0010, 4'b0000, 6'b000000, 6'b000000, 1, SD0, 0,     0));
    vecs.push_back(v(0, 4'b0110, 4'b0000, 32'h10, 4'b0000, 4'b0000, 4'b0000, 6'b000001, 6'b000000, 1, 0,   32'h10, WD2));
    vecs.push_back(v(0, 4'b0110, 4'b0000, 32'h10, 4'b0010, 4'b0100, 4'b0000, 6'b000000, 6'b000000, 1, SD0, 0,     0));
    vecs.push_back(v(0, 4'b0110, 4'b0000, 32'h10, 4'b0000, 4'b0000, 4'b0000, 6'b000001, 6'b000000, 1, 0,   32'h10, WD1));
    vecs.push_back(v(0, 4'b0110, 4'b0000, 32'h10, 4'b0100, 4'b0010, 4'b0000, 6'b000000, 6'b000000, 1, SD0, 0,     0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 32'h10, 4'b0000, 4'b0000, 4'b0000, 6'b000001, 6'b000000, 1, 0,   32'h10, WD2));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 32'h10, 4'b0000, 4'b0100, 4'b0000, 6'b000000, 6'b000000, 0, SD0, 0,     0));
    // Decode error: m2 writes to unmapped slave 7
    vecs.push_back(v(0, 4'b0100, 4'b0100, 32'h7000_0000, 4'b0100, 4'b0000, 4'b0000, 6'b000000, 6'b000000, 1, 0, 0, 0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 32'h7000_0000, 4'b0000, 4'b0000, 4'b0000, 6'b000000, 6'b000000, 1, 0, 0, 0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 32'h7000_0000, 4'b0000, 4'b0100, 4'b0100, 6'b000000, 6'b000000, 0, 0, 0, 0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 32'h0,         4'b0000, 4'b0000, 4'b0000, 6'b000000, 6'b000000, 0, 0, 0, 0));
    // Back-to-back m0 read/write/read to slave 0
    vecs.push_back(v(0, 4'b0001, 4'b0000, 32'h100, 4'b0001, 4'b0000, 4'b0000, 6'b000000, 6'b000000, 1, 0,   0,      0));
    vecs.push_back(v(0, 4'b0001, 4'b0001, 32'h100, 4'b0000, 4'b0000, 4'b0000, 6'b000001, 6'b000000, 1, 0,   32'h100, WD0));
    vecs.push_back(v(0, 4'b0001, 4'b0001, 32'h100, 4'b0001, 4'b0001, 4'b0000, 6'b000000, 6'b000000, 1, SD0, 0,      0));
    vecs.push_back(v(0, 4'b0001, 4'b0000, 32'h100, 4'b0000, 4'b0000, 4'b0000, 6'b000001, 6'b000001, 1, 0,   32'h100, WD0));
    vecs.push_back(v(0, 4'b0001, 4'b0000, 32'h100, 4'b0001, 4'b0001, 4'b0000, 6'b000000, 6'b000000, 1, 0,   0,      0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 32'h100, 4'b0000, 4'b0000, 4'b0000, 6'b000001, 6'b000000, 1, 0,   32'h100, WD0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 32'h100, 4'b0000, 4'b0001, 4'b0000, 6'b000000, 6'b000000, 0, SD0, 0,      0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 32'h0,   4'b0000, 4'b0000, 4'b0000, 6'b000000, 6'b000000, 0, 0,   0,      0));
    // Reset during ACCESS of an m1 write, then a fresh m1 read
    vecs.push_back(v(0, 4'b0010, 4'b0010, 32'h2000_0008, 4'b0010, 4'b0000, 4'b0000, 6'b000000, 6'b000000, 0, 0,   0,     0));
    vecs.push_back(v(1, 4'b0000, 4'b0000, 32'h2000_0008, 4'b0000, 4'b0000, 4'b0000, 6'b000100, 6'b000100, 1, 0,   32'h8, WD1));
    vecs.push_back(v(0, 4'b0010, 4'b0000, 32'h2000_0008, 4'b0010, 4'b0000, 4'b0000, 6'b000000, 6'b000000, 0, 0,   0,     0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 32'h2000_0008, 4'b0000, 4'b0000, 4'b0000, 6'b000100, 6'b000000, 1, 0,   32'h8, WD1));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 32'h2000_0008, 4'b0000, 4'b0010, 4'b0000, 6'b000000, 6'b000000, 0, SD2, 0,     0));
    // Hold flag: m1 alone does not hold, m0 does from the same cycle
    vecs.push_back(v(0, 4'b0010, 4'b0000, 32'h0, 4'b0010, 4'b0000, 4'b0000, 6'b000000, 6'b000000, 0, 0,   0, 0));
    vecs.push_back(v(0, 4'b0001, 4'b0000, 32'h0, 4'b0000, 4'b0000, 4'b0000, 6'b000001, 6'b000000, 1, 0,   0, WD1));
    vecs.push_back(v(0, 4'b0001, 4'b0000, 32'h0, 4'b0001, 4'b0010, 4'b0000, 6'b000000, 6'b000000, 1, SD0, 0, 0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 32'h0, 4'b0000, 4'b0000, 4'b0000, 6'b000001, 6'b000000, 1, 0,   0, WD0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 32'h0, 4'b0000, 4'b0001, 4'b0000, 6'b000000, 6'b000000, 0, SD0, 0, 0));

    for (int i = 0; i < NUM_M; i++) m_data_i[i*DW +: DW] = WD0 + 32'(i);
    for (int s = 0; s < NUM_S; s++) s_data_i[s*DW +: DW] = (s == 1) ? SD1 : (SD0 | 32'(s));

    drive(1, 4'b0000, 4'b0000, 32'h0);
    repeat (2) @(posedge clk);

    foreach (vecs[r]) begin
      @(posedge clk);
      #1;
      drive(vecs[r].rst, vecs[r].req, vecs[r].we, vecs[r].addr);
      @(negedge clk);
      cur_row = r;
      check_vec(vecs[r]);
    end

    // Reset asserted during RESP: no response pulse survives into the next cycle.
    cur_row = 100;
    @(posedge clk); #1;
    drive(0, 4'b0001, 4'b0000, 32'h3000_0004);
    @(negedge clk);
    check("rst_resp_gnt", 192'(m_gnt_o), 192'(4'b0001));
    @(posedge clk); #1;
    drive(0, 4'b0000, 4'b0000, 32'h0);
    @(negedge clk);
    check("rst_resp_sreq", 192'(s_req_o), 192'(6'b001000));
    check("rst_resp_saddr", 192'(s_addr_o[3*AW +: AW]), 192'(32'h4));
    @(posedge clk); #1;
    drive(1, 4'b0000, 4'b0000, 32'h0);
    @(posedge clk); #1;
    drive(0, 4'b0000, 4'b0000, 32'h0);
    @(negedge clk);
    check("rst_resp_rvalid", 192'(m_rvalid_o), 192'(4'b0000));
    check("rst_resp_idle_sreq", 192'(s_req_o), 192'(6'b000000));
    check("rst_resp_hold", 192'(hold_flag_o), 192'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rib_xbar.md
# rib_xbar

Parametrised successor to the core's RIB interconnect: a registered, transaction-based shared bus connecting NUM_M masters to NUM_S slaves. It adds a per-master req/gnt/rvalid handshake, a fixed top-priority master with round-robin among the rest, and a decode-error response. Slave select comes from the top SEL_W address bits. It sits between the core's bus masters (LSU, instruction fetch, DMA, JTAG debug) and the memory and peripheral slaves. Slaves are synchronous-read with one cycle of latency.

## Interface
- NUM_M, 4, number of masters (2..8)
- NUM_S, 6, number of slaves (1..2^SEL_W)
- AW, 32, address width
- DW, 32, data width
- SEL_W, 4, top address bits used as the slave index
- PRIO_M, 3, master that always wins arbitration (debug)
- HOLD_MASK, 4'b1101, masters whose pending request raises hold_flag_o
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- m_req_i  in  NUM_M  request per master
- m_we_i  in  NUM_M  write flag per master
- m_addr_i  in  NUM_M*AW  packed addresses; master i occupies slice [i*AW +: AW]
- m_data_i  in  NUM_M*DW  packed write data
- m_gnt_o  out  NUM_M  one-hot grant pulse
- m_rvalid_o  out  NUM_M  one-hot response pulse
- m_err_o  out  NUM_M  decode error; valid only with m_rvalid_o
- m_data_o  out  NUM_M*DW  read data; valid only with m_rvalid_o, otherwise 0
- s_req_o  out  NUM_S  one-hot slave access strobe
- s_we_o  out  NUM_S  slave write enable
- s_addr_o  out  NUM_S*AW  slave address, with the top SEL_W bits forced to 0
- s_data_o  out  NUM_S*DW  slave write data
- s_data_i  in  NUM_S*DW  slave read data, valid the cycle after s_req_o
- hold_flag_o  out  1  pipeline hold request to the core

## Operation
- FSM states: IDLE, ACCESS, RESP. Transitions:
  - IDLE with any request -> ACCESS.
  - ACCESS -> RESP, always.
  - RESP with any request -> ACCESS; otherwise -> IDLE.
- Arbitration runs only in IDLE and RESP.
  - If m_req_i[PRIO_M] is set, master PRIO_M wins.
  - Otherwise the first requester scanning upward (with wrap) from rr_ptr+1 wins, excluding PRIO_M.
  - rr_ptr is updated to the winner on every non-PRIO_M grant.
- Grant cycle:
  - m_gnt_o[w] = 1, combinational.
  - The winner index, addr, data, we and sel = addr[AW-1 -: SEL_W] are latched at the clock edge.
- ACCESS, when sel < NUM_S:
  - s_req_o[sel] = 1; s_we_o[sel] = latched we.
  - s_addr_o slice = {SEL_W'b0, addr[AW-SEL_W-1:0]}; s_data_o slice = latched data.
  - All other slave slices are 0.
- ACCESS, when sel >= NUM_S: no slave strobe; an error flag is latched.
- RESP:
  - m_rvalid_o[w] = 1.
  - m_data_o slice w = s_data_i slice sel for a read; 0 for a write or an error.
  - m_err_o[w] = error flag.
- Writes also receive a RESP pulse, which acts as the write ack.
- Master rules:
  - Hold m_req_i and its payload stable until m_gnt_o.
  - After the grant, the payload is don't-care.
  - A master may re-request during its own RESP and be granted in that same cycle.
- hold_flag_o = |(m_req_i & HOLD_MASK) | (state == ACCESS); combinational.

## Timing
- Reset values: state = IDLE, rr_ptr = NUM_M-1 (so master 0 has first round-robin priority), latched registers = 0. All outputs are 0 once rst is seen.
- Latency: request at cycle T (bus free) -> gnt at T -> s_req_o at T+1 -> rvalid/data at T+2.
- Throughput: one transaction per 2 cycles under continuous requests, because RESP overlaps the next grant.
- No grant in ACCESS; requests arriving then wait until RESP.
- Simultaneous requests: exactly one m_gnt_o bit is set, never more.
- Reset mid-transaction: rst asserted in ACCESS or RESP -> the next cycle is IDLE with no rvalid. A write strobe already issued in ACCESS is not retracted.
- Outputs are one-hot or zero in every cycle.

## Structure
- Add FSM state encodings and RIB_SEL_W to the shared defines.v.
- Sub-module rib_rr_arbiter contains only combinational winner select and rr_ptr. Its inputs are req, PRIO_M and ptr; its outputs are gnt one-hot and index.
- rib_xbar holds the FSM, the transaction latch and the generate-loop slave and master muxes. Target size is about 250 lines total.

## Test plan
- Single read: m0 reads 0x1000_0040 with slave 1 returning 0xDEAD_BEEF -> gnt[0] at T, s_req_o[1] with s1 addr 0x0000_0040 at T+1, rvalid[0] with data 0xDEAD_BEEF at T+2.
- Priority: m1, m2 and m3 request together -> m3 is granted first. Then, with m3 dropped, m1 and m2 alternate round-robin in the order m1, m2, m1, m2.
- Decode error: m2 writes 0x7000_0000 with NUM_S = 6 -> no s_req_o, rvalid[2] with err[2] = 1 and data 0.
- Back-to-back: m0 requests continuously with alternating read/write to slave 0 -> gnt every 2 cycles, s_we_o alternating, rvalid every 2 cycles.
- Reset in ACCESS: rst during ACCESS -> no rvalid next cycle, state IDLE, a fresh request is granted on the first cycle after rst deasserts.
- Hold: only m1 requests -> hold_flag_o = 0 except during ACCESS. m0 requests -> hold_flag_o = 1 from the same cycle.
